fifo_write_arbiter: RTL

//  Shares one 16-deep sync FIFO write port among NUM_REQ producers.

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/fifo_write_arbiter_rr_pick.sv | 37 +++
 rtl/fifo_write_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// +----------------------------------------------------------------------+
// | fifo_arb_pkg: shared types and widths for the FIFO write arbiter.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int BURST_CNT_W = 4;
  localparam int STAT_W      = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick: combinational round-robin picker, first request at/after    |
// | the start pointer with wrap-around.  Revision: 1.0                    |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] start_i,
  output logic [$clog2(NUM_REQ)-1:0] winner_o,
  output logic                       any_o
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] w_idx;
  logic            w_found;

  always_comb begin
    winner_o = '0;
    any_o    = |req_i;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = ID_W'((int'(start_i) + i) % NUM_REQ);
      if (!w_found && req_i[w_idx]) begin
        winner_o = w_idx;
        w_found  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
// +----------------------------------------------------------------------+
// | fifo_write_arbiter: round-robin, burst-bounded sharing of one FIFO    |
// | write port. Optional FIFO_ARB_STATS_EN adds per-producer beat counts. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]            fifo_data_in,
  output logic                         fifo_write_en,
  input  logic                         fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         grant_active
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]    stat_beats
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [ID_W-1:0]        w_winner;
  logic                   w_any;
  logic                   w_beat;
  logic [ID_W-1:0]        w_next_ptr;
  logic [BURST_CNT_W-1:0] w_burst_inc;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i    (req_valid),
    .start_i  (rr_ptr_q),
    .winner_o (w_winner),
    .any_o    (w_any)
  );

  // Gating with rst keeps a beat from issuing in the cycle reset is taken.
  assign w_beat      = (state_q == GRANT) && req_valid[grant_id_q] && !fifo_full && !rst;
  assign w_next_ptr  = (grant_id_q == ID_W'(NUM_REQ-1)) ? '0 : grant_id_q + ID_W'(1);
  assign w_burst_inc = burst_cnt_q + BURST_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (w_any) begin
          state_d     = GRANT;
          grant_id_d  = w_winner;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!req_valid[grant_id_q]) begin
          state_d  = IDLE;
          rr_ptr_d = w_next_ptr;
        end else if (w_beat) begin
          burst_cnt_d = w_burst_inc;
          if (w_burst_inc == BURST_CNT_W'(MAX_BURST)) begin
            state_d  = IDLE;
            rr_ptr_d = w_next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_write_en = 1'b0;
    fifo_data_in  = '0;
    req_ready     = '0;
    if (state_q == GRANT && !rst) begin
      fifo_write_en         = w_beat;
      req_ready[grant_id_q] = w_beat;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_id_q == ID_W'(i)) begin
          fifo_data_in = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign grant_id     = grant_id_q;
  assign grant_active = (state_q == GRANT);

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    always_ff @(posedge clk) begin
      if (rst) begin
        stat_q[gi] <= '0;
      end else if (req_ready[gi]) begin
        stat_q[gi] <= sat_inc(stat_q[gi]);
      end
    end
    assign stat_beats[gi*STAT_W +: STAT_W] = stat_q[gi];
  end
`else
  // Beat statistics are not built in this configuration.
`endif

endmodule

`default_nettype wire
